// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//
// Holds the fetch address and advances it by 4 whenever fetch is accepted.
// It redirects on a resolved branch or jalr; if the redirect arrives while
// the pipeline is stalled, the target is parked in a pending register until
// the stall clears. ecall/ebreak moves it into a HALTED state, which only
// reset leaves.
//
// Optional feature: define PC_MISALIGN_EN to reject redirect targets that are
// not word aligned. A rejected redirect leaves pc and state unchanged and
// pulses `misaligned` for one cycle. Without the macro the port is absent and
// the target's low two bits are forced to zero.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   stall            hazard hold, suppresses sequential advance
//   branch_taken     branch/jal resolved taken (1-cycle pulse)
//   branch_base      PC of the redirecting instruction
//   branch_offset    pre-shifted branch immediate
//   jalr_taken       jalr resolved (1-cycle pulse), wins over branch_taken
//   jalr_target      rs1+imm from the ALU
//   halt             ecall/ebreak halt request, overrides everything
//   fetch_ready      imem accepts pc this cycle
//   pc               registered fetch address
//   pc_plus4         pc+4 (link value)
//   fetch_valid      pc is a valid fetch request
//   halted           high in HALTED
//   misaligned       (PC_MISALIGN_EN only) rejected-redirect pulse
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jalr_taken,
  input  logic [31:0] jalr_target,
  input  logic        halt,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
`ifdef PC_MISALIGN_EN
  output logic        misaligned,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

  state_t      state;
  logic [31:0] pending;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        take;

  assign redirect   = jalr_taken | branch_taken;
  // jalr wins when both resolve in the same cycle; its bit 0 is always dropped.
  assign raw_target = jalr_taken ? (jalr_target & ~32'h1)
                                 : (branch_base + branch_offset);

`ifdef PC_MISALIGN_EN
  logic bad_target;
  assign bad_target = raw_target[1:0] != 2'b00;
  assign target     = raw_target;
  assign take       = redirect & ~bad_target;
`else
  assign target     = raw_target & ~32'h3;
  assign take       = redirect;
`endif

  assign pc_plus4    = pc + 32'd4;
  assign fetch_valid = (state == RUN) & ~stall & ~rst;
  assign halted      = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      state   <= RUN;
      pending <= 32'h0;
`ifdef PC_MISALIGN_EN
      misaligned <= 1'b0;
`endif
    end else begin
`ifdef PC_MISALIGN_EN
      // Pulse only for redirects that would otherwise have been acted on.
      misaligned <= redirect & bad_target & ~halt & (state != HALTED);
`endif
      case (state)
        RUN: begin
          if (halt) begin
            state   <= HALTED;
            pending <= 32'h0;
          end else if (take) begin
            if (!stall) begin
              // Outstanding fetch is abandoned, so fetch_ready is ignored.
              pc <= target;
            end else begin
              pending <= target;
              state   <= PEND;
            end
          end else if (!redirect && !stall && fetch_ready) begin
            pc <= pc_plus4;
          end
        end
        PEND: begin
          if (halt) begin
            state   <= HALTED;
            pending <= 32'h0;
          end else begin
            if (take) pending <= target;
            if (!stall) begin
              // A redirect arriving in the release cycle is newer than pending.
              pc    <= take ? target : pending;
              state <= RUN;
            end
          end
        end
        default: ; // HALTED: frozen until reset
      endcase
    end
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hazard hold; sequential PC advance suppressed.
REQ-005 SHALL have port branch_taken  input  1  one-cycle pulse, conditional branch/jal resolved taken.
REQ-006 SHALL have port branch_base  input  32  PC of the redirecting instruction.
REQ-007 SHALL have port branch_offset  input  32  immediate already shifted left by 1 by the upstream shift stage.
REQ-008 SHALL have port jalr_taken  input  1  one-cycle pulse, jalr resolved.
REQ-009 SHALL have port jalr_target  input  32  rs1+imm from the ALU.
REQ-010 SHALL have port halt  input  1  ecall/ebreak halt request.
REQ-011 SHALL have port fetch_ready  input  1  instruction memory accepts pc this cycle.
REQ-012 SHALL have port pc  output  32  current fetch address (registered).
REQ-013 SHALL have port pc_plus4  output  32  pc+4, combinational, link value.
REQ-014 SHALL have port fetch_valid  output  1  pc is a valid fetch request.
REQ-015 SHALL have port halted  output  1  high in HALTED state.
REQ-016 SHALL have port misaligned  output  1  present only with PC_MISALIGN_EN.

Function
REQ-017 SHALL implement states RUN, PEND, HALTED.
REQ-018 SHALL compute branch target = branch_base + branch_offset, modulo 2^32; jalr target = jalr_target with bit 0 cleared.
REQ-019 SHALL prioritise redirects jalr_taken over branch_taken when both pulse in one cycle.
REQ-020 SHALL in RUN, stall=0, fetch_ready=1, no redirect: pc <= pc+4 next edge (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 SHALL in RUN with fetch_ready=0 or stall=1 and no redirect: hold pc.
REQ-022 SHALL in RUN, redirect with stall=0: pc <= target next edge regardless of fetch_ready (outstanding fetch abandoned); latency 1 cycle.
REQ-023 SHALL in RUN, redirect with stall=1: latch target into pending register, pc held, go to PEND.
REQ-024 SHALL in PEND: overwrite pending with any newer redirect (jalr priority per REQ-019); when stall=0, pc <= pending, return to RUN.
REQ-025 SHALL assert fetch_valid = (state==RUN) and stall=0 and rst=0; 0 in PEND and HALTED.
REQ-026 SHALL on halt=1 in RUN or PEND: go to HALTED next edge, pc frozen, pending and same-cycle redirect discarded; halt overrides all.
REQ-027 SHALL remain in HALTED, ignoring all inputs, until rst.
REQ-028 SHALL drive halted=1 only in HALTED.

Reset
REQ-029 SHALL on rst=1, immediately and asynchronously: pc=RESET_PC, state=RUN, pending=0, misaligned=0.
REQ-030 SHALL hold fetch_valid=0 while rst=1; first fetch of RESET_PC on first edge after rst deasserts.
REQ-031 SHALL abandon any PEND or HALTED state when rst asserts mid-operation.

Configuration
REQ-032 SHALL with PC_MISALIGN_EN defined: redirect target with bits[1:0]!=2'b00 not loaded, pc/state unchanged, misaligned=1 for exactly one cycle after the redirect edge.
REQ-033 SHALL without PC_MISALIGN_EN: misaligned port absent, target loaded with bits[1:0] forced to 2'b00.

Verification
REQ-034 SHALL cover: reset release, fetch_ready=1, stall=0 for 3 cycles -> pc 0x0,0x4,0x8,0xC, fetch_valid=1.
REQ-035 SHALL cover: branch_taken, base=0x100, offset=0xFFFF_FFF0 -> pc=0x0F0 next cycle.
REQ-036 SHALL cover: stall=1 and branch to 0x200 then jalr to 0x301 in PEND, stall drops -> pc=0x300, fetch_valid 0 during PEND.
REQ-037 SHALL cover: pc=0xFFFF_FFFC, advance -> pc=0x0; pc_plus4 at 0xFFFF_FFFC = 0x0.
REQ-038 SHALL cover: halt with simultaneous branch -> halted=1, pc frozen, fetch_valid=0; rst mid-HALTED -> pc=RESET_PC.
REQ-039 SHALL cover (PC_MISALIGN_EN): branch target 0x102 -> pc unchanged, misaligned one-cycle pulse; without macro -> pc=0x100.
